// File: rtl/unidade_busca.sv
// Instruction-fetch stage: PC register, handshaked imem read, valid/ready hand-off to decode.
// Optional ack timeout enabled by defining BUSCA_TIMEOUT_EN.
module unidade_busca #(
  parameter int unsigned MEM_DEPTH      = 32,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pc_step,
  input  logic        branch_taken,
  input  logic [11:0] branch_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic        halt,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, HALT, FAULT} state_t;

  localparam logic [31:0] PC_LIMIT = 32'(4 * MEM_DEPTH);

  state_t      state;
  logic [31:0] step_target;
  logic        pc_legal;

`ifdef BUSCA_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
`endif

  // Branch immediate is in halfwords: sign-extend, then shift left by one.
  always_comb begin
    step_target = pc + 32'd4;
    if (branch_taken)
      step_target = pc + {{19{branch_imm[11]}}, branch_imm, 1'b0};
  end

  assign pc_legal  = (pc[1:0] == 2'b00) && (pc < PC_LIMIT);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halt        <= 1'b0;
      fault       <= 1'b0;
`ifdef BUSCA_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pc_step) begin
            pc <= step_target;
          end else if (start) begin
            if (pc_legal) begin
              state    <= REQ;
              imem_req <= 1'b1;
`ifdef BUSCA_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end
        REQ: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            imem_req <= 1'b0;
            if (imem_rdata == '0) begin
              state <= HALT;
              halt  <= 1'b1;
            end else begin
              state       <= HOLD;
              instr_valid <= 1'b1;
            end
          end
`ifdef BUSCA_TIMEOUT_EN
          // Ack is tested first so an ack on the limit cycle still completes the fetch.
          else if (wait_cnt == WAIT_LAST) begin
            state    <= FAULT;
            fault    <= 1'b1;
            imem_req <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Directed self-checking bench for unidade_busca: table of PC-update vectors plus fetch sequences.
module tb_unidade_busca;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pc_step = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_imm = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        halt;
  logic        fault;

  int unsigned tests = 0;
  int unsigned fails = 0;

  unidade_busca #(
    .MEM_DEPTH(32),
    .RESET_PC(32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pc_step(pc_step),
    .branch_taken(branch_taken),
    .branch_imm(branch_imm),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .pc(pc),
    .halt(halt),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        step;
    logic        taken;
    logic [11:0] imm;
    logic [31:0] exp_pc;
    logic        exp_req;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_step(input logic taken, input logic [11:0] imm, input logic [31:0] exp_pc);
    pc_step = 1'b1; branch_taken = taken; branch_imm = imm;
    tick();
    pc_step = 1'b0; branch_taken = 1'b0; branch_imm = '0;
    check("step_pc", pc, exp_pc);
  endtask

  // Returns at the negedge where instr_valid (or halt) first becomes visible.
  task automatic fetch(input logic [31:0] word, input logic [31:0] addr,
                       input int unsigned waits, input logic ready);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("req_high", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, addr);
    for (int unsigned w = 0; w < waits; w++) begin
      tick();
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = word; instr_ready = ready;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check("req_dropped", {31'b0, imem_req}, 32'd0);
    if (word != '0) begin
      check("valid", {31'b0, instr_valid}, 32'd1);
      check("instr", instr, word);
      check("instr_pc", instr_pc, addr);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 12'h000, 32'h0000_0004, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 12'h000, 32'h0000_0008, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 12'hFFC, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 12'h006, 32'h0000_000C, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 12'hFFC, 32'h0000_000C, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 12'h800, 32'hFFFF_F00C, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 12'h7FF, 32'h0000_000A, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 12'hFFB, 32'h0000_0000, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 12'h000, 32'h0000_0004, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 12'h000, 32'h0000_0008, 1'b0};

    // Reset values
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic fetch, zero wait states, decode ready
    fetch(32'h0020_8133, 32'h0, 0, 1'b1);
    tick();
    instr_ready = 1'b0;
    check("valid_after_accept", {31'b0, instr_valid}, 32'd0);

    // PC update table (includes start+pc_step collision)
    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start; pc_step = vecs[i].step;
      branch_taken = vecs[i].taken; branch_imm = vecs[i].imm;
      tick();
      start = 1'b0; pc_step = 1'b0; branch_taken = 1'b0; branch_imm = '0;
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
    end

    // Backpressure with 2 ack wait states; commands and acks during HOLD are ignored
    fetch(32'h00A0_0093, 32'h8, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start = 1'b1; pc_step = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      end
      tick();
      start = 1'b0; pc_step = 1'b0; imem_ack = 1'b0;
      check("bp_valid", {31'b0, instr_valid}, 32'd1);
      check("bp_instr", instr, 32'h00A0_0093);
      check("bp_instr_pc", instr_pc, 32'h8);
      check("bp_req", {31'b0, imem_req}, 32'd0);
      check("bp_pc", pc, 32'h8);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_valid_drop", {31'b0, instr_valid}, 32'd0);

    // Reset in the middle of a request, late ack afterwards
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mid_req_high", {31'b0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_req", {31'b0, imem_req}, 32'd0);

    // Program end: all-zero word
    fetch(32'h0, 32'h0, 0, 1'b1);
    check("halt", {31'b0, halt}, 32'd1);
    check("halt_valid", {31'b0, instr_valid}, 32'd0);
    start = 1'b1; pc_step = 1'b1;
    tick();
    start = 1'b0; pc_step = 1'b0;
    tick();
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_pc", pc, 32'h0);
    check("halt_sticky", {31'b0, halt}, 32'd1);
    check("halt_valid2", {31'b0, instr_valid}, 32'd0);
    do_reset();
    check("halt_cleared", {31'b0, halt}, 32'd0);

    // Out-of-range PC (128)
    do_step(1'b1, 12'h040, 32'h0000_0080);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("range_fault", {31'b0, fault}, 32'd1);
    check("range_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("range_fault_sticky", {31'b0, fault}, 32'd1);
    check("range_req2", {31'b0, imem_req}, 32'd0);
    do_reset();
    check("fault_cleared", {31'b0, fault}, 32'd0);

    // Highest legal PC (124) fetches normally
    do_step(1'b1, 12'h03E, 32'h0000_007C);
    fetch(32'h0000_0013, 32'h7C, 0, 1'b1);
    tick();
    check("edge_fault", {31'b0, fault}, 32'd0);
    do_reset();

    // Misaligned PC
    do_step(1'b1, 12'h001, 32'h0000_0002);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("misalign_fault", {31'b0, fault}, 32'd1);
    check("misalign_req", {31'b0, imem_req}, 32'd0);
    do_reset();

    // No ack: timeout fault or indefinite wait depending on build
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_req", {31'b0, imem_req}, 32'd1);
`ifdef BUSCA_TIMEOUT_EN
    begin
      int unsigned k;
      k = 0;
      while (!fault && k < 40) begin
        tick();
        k++;
      end
      check("to_cycles", k, 32'd16);
      check("to_req_drop", {31'b0, imem_req}, 32'd0);
    end
`else
    repeat (20) tick();
    check("nto_req", {31'b0, imem_req}, 32'd1);
    check("nto_fault", {31'b0, fault}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0; instr_ready = 1'b0;
    check("nto_valid", {31'b0, instr_valid}, 32'd1);
    check("nto_instr", instr, 32'h0000_0013);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
